// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between control unit and mul_div_unit
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] Zhigh;
  logic [WIDTH-1:0] Zlow;

  modport master (
    output start, op, A, B,
    input  busy, done, div_by_zero, Zhigh, Zlow
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, div_by_zero, Zhigh, Zlow
  );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative signed Booth multiply / restoring divide, one bit per clock
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          clear,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             bit_q, bit_d;
  logic [WIDTH:0]   m_q, m_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] zhigh_q, zhigh_d;
  logic [WIDTH-1:0] zlow_q, zlow_d;

  logic [WIDTH:0]   a_ext, b_ext, b_mag;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH:0]   booth_sum, mul_hi, div_shift, div_hi;
  logic [WIDTH-1:0] mul_lo, div_lo, quo_fix, rem_fix;
  logic             div_ge;

  always_comb begin
    a_ext = {bus.A[WIDTH-1], bus.A};
    b_ext = {bus.B[WIDTH-1], bus.B};
    // -2^(W-1) negates to itself as a W-bit unsigned, which is its exact magnitude
    a_mag = bus.A[WIDTH-1] ? -bus.A : bus.A;
    b_mag = b_ext[WIDTH] ? -b_ext : b_ext;

    // Booth step: add/subtract in W+1 bits so the shifted-in sign is the true sign
    case ({lo_q[0], bit_q})
      2'b01:   booth_sum = hi_q + m_q;
      2'b10:   booth_sum = hi_q - m_q;
      default: booth_sum = hi_q;
    endcase
    mul_hi = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mul_lo = {booth_sum[0], lo_q[WIDTH-1:1]};

    div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_ge    = (div_shift >= m_q);
    div_hi    = div_ge ? (div_shift - m_q) : div_shift;
    div_lo    = {lo_q[WIDTH-2:0], div_ge};
    quo_fix   = neg_quo_q ? -div_lo : div_lo;
    rem_fix   = neg_rem_q ? -div_hi[WIDTH-1:0] : div_hi[WIDTH-1:0];

    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    bit_d     = bit_q;
    m_d       = m_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    zhigh_d   = zhigh_q;
    zlow_d    = zlow_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (bus.start) begin
          op_d  = bus.op;
          dbz_d = 1'b0;
          if (bus.op && bus.B == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
            zhigh_d = bus.A;
            zlow_d  = '1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            cnt_d   = CW'(WIDTH - 1);
            hi_d    = '0;
            bit_d   = 1'b0;
            if (bus.op) begin
              lo_d      = a_mag;
              m_d       = b_mag;
              neg_quo_d = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
              neg_rem_d = bus.A[WIDTH-1];
            end else begin
              lo_d = bus.B;
              m_d  = a_ext;
            end
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q) begin
          hi_d = div_hi;
          lo_d = div_lo;
        end else begin
          hi_d  = mul_hi;
          lo_d  = mul_lo;
          bit_d = lo_q[0];
        end
        if (cnt_q == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          zhigh_d = op_q ? rem_fix : mul_hi[WIDTH-1:0];
          zlow_d  = op_q ? quo_fix : mul_lo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      bit_q     <= 1'b0;
      m_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      zhigh_q   <= '0;
      zlow_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      bit_q     <= bit_d;
      m_q       <= m_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      zhigh_q   <= zhigh_d;
      zlow_q    <= zlow_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.Zhigh       = zhigh_q;
  assign bus.Zlow        = zlow_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed bench for mul_div_unit with a cycle-level arithmetic model
module tb_mul_div_unit;
  logic clock = 1'b0;
  logic clear;
  int   n_pass = 0;
  int   n_total = 0;
  bit   chk_en = 1'b0;

  mul_div_unit_if #(.WIDTH(32)) bus ();
  mul_div_unit #(.WIDTH(32)) dut (.clock(clock), .clear(clear), .bus(bus.slave));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: results from plain 64-bit arithmetic, timing as a countdown of remaining cycles
  logic        m_busy = 0, m_done = 0, m_dbz = 0;
  logic [31:0] m_zh = 0, m_zl = 0, p_zh = 0, p_zl = 0;
  int          m_left = 0;
  longint      pa, pb, prod, q, r;

  always @(posedge clock) begin
    if (clear) begin
      m_busy = 0; m_done = 0; m_dbz = 0; m_zh = 0; m_zl = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_zh = p_zh; m_zl = p_zl;
        end
      end else if (bus.start) begin
        m_dbz = 0;
        pa = $signed(bus.A);
        pb = $signed(bus.B);
        if (!bus.op) begin
          prod = pa * pb;
          p_zh = prod[63:32];
          p_zl = prod[31:0];
          m_left = 32; m_busy = 1;
        end else if (pb == 0) begin
          m_dbz = 1; m_done = 1; m_zh = bus.A; m_zl = 32'hFFFF_FFFF;
        end else begin
          q = pa / pb;
          r = pa % pb;
          p_zl = q[31:0];
          p_zh = r[31:0];
          m_left = 32; m_busy = 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy", 64'(bus.busy), 64'(m_busy));
      chk("done", 64'(bus.done), 64'(m_done));
      chk("div_by_zero", 64'(bus.div_by_zero), 64'(m_dbz));
      chk("Zhigh", 64'(bus.Zhigh), 64'(m_zh));
      chk("Zlow", 64'(bus.Zlow), 64'(m_zl));
    end
  end

  // Called at a negedge; start is seen by the following rising edge
  task automatic run_op(input string nm, input logic o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ezh, input logic [31:0] ezl, input int elat);
    int k;
    int nb;
    bus.start = 1; bus.op = o; bus.A = a; bus.B = b;
    k = 0; nb = 0;
    do begin
      @(negedge clock);
      bus.start = 0; bus.A = $urandom; bus.B = $urandom;
      k++;
      if (bus.busy) nb++;
    end while (!bus.done && k < 40);
    chk({nm, "_latency"}, 64'(k), 64'(elat));
    chk({nm, "_busy_cycles"}, 64'(nb), 64'(elat - 1));
    chk({nm, "_zhigh"}, 64'(bus.Zhigh), 64'(ezh));
    chk({nm, "_zlow"}, 64'(bus.Zlow), 64'(ezl));
  endtask

  initial begin
    int k;
    int nd;
    int first;
    clear = 1; bus.start = 0; bus.op = 0; bus.A = 0; bus.B = 0;
    repeat (2) @(negedge clock);
    chk_en = 1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_zhigh", 64'(bus.Zhigh), 64'd0);
    chk("rst_zlow", 64'(bus.Zlow), 64'd0);
    clear = 0;
    @(negedge clock);

    run_op("mul_7x-3", 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
    run_op("b2b_div_-7/2", 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    @(negedge clock);
    run_op("mul_min_sq", 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33);
    @(negedge clock);
    run_op("mul_m1_sq", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 33);
    @(negedge clock);
    run_op("mul_max_sq", 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h1, 33);
    @(negedge clock);
    run_op("div_ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
    @(negedge clock);
    run_op("div_100/7", 1, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    @(negedge clock);
    run_op("div_-100/7", 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 33);
    @(negedge clock);
    run_op("div_5/min", 1, 32'd5, 32'h8000_0000, 32'd5, 32'd0, 33);
    @(negedge clock);
    run_op("div_min/3", 1, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 32'hD555_5556, 33);
    @(negedge clock);
    run_op("dbz", 1, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1);
    chk("dbz_flag", 64'(bus.div_by_zero), 64'd1);
    @(negedge clock);
    chk("dbz_sticky", 64'(bus.div_by_zero), 64'd1);
    run_op("mul_after_dbz", 0, 32'd3, 32'd4, 32'd0, 32'd12, 33);
    chk("dbz_cleared", 64'(bus.div_by_zero), 64'd0);

    // A start during RUN must be dropped
    @(negedge clock);
    bus.start = 1; bus.op = 0; bus.A = 32'd7; bus.B = 32'hFFFF_FFFD;
    k = 0; nd = 0; first = 0;
    while (k < 80) begin
      @(negedge clock);
      bus.start = 0;
      k++;
      if (bus.done) begin
        nd++;
        if (first == 0) begin
          first = k;
          chk("ignored_zlow", 64'(bus.Zlow), 64'hFFFF_FFEB);
        end
      end
      if (k == 9) begin
        bus.start = 1; bus.op = 1; bus.A = 32'd50; bus.B = 32'd5;
      end
    end
    chk("ignored_latency", 64'(first), 64'd33);
    chk("ignored_done_count", 64'(nd), 64'd1);

    // Clear mid-operation
    @(negedge clock);
    bus.start = 1; bus.op = 0; bus.A = 32'd9; bus.B = 32'd9;
    repeat (14) begin
      @(negedge clock);
      bus.start = 0;
    end
    clear = 1;
    @(negedge clock);
    clear = 0;
    chk("clr_busy", 64'(bus.busy), 64'd0);
    chk("clr_done", 64'(bus.done), 64'd0);
    chk("clr_zhigh", 64'(bus.Zhigh), 64'd0);
    chk("clr_zlow", 64'(bus.Zlow), 64'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.done) nd++;
    end
    chk("clr_no_done", 64'(nd), 64'd0);
    run_op("after_clear", 0, 32'd9, 32'd9, 32'd0, 32'd81, 33);

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
